// File: rtl/wr_pps_monitor_if.sv
// Register-side view of the PPS monitor: PPS/clear inputs and the
// status/counter outputs that software reads.
interface wr_pps_monitor_if;
   logic        pps_i;
   logic        clr_i;
   logic        pps_pulse_o;
   logic [31:0] period_o;
   logic        period_valid_o;
   logic [31:0] pps_count_o;
   logic [15:0] err_count_o;
   logic        locked_o;
   logic        missing_o;

   modport master (
      output pps_i,
      output clr_i,
      input  pps_pulse_o,
      input  period_o,
      input  period_valid_o,
      input  pps_count_o,
      input  err_count_o,
      input  locked_o,
      input  missing_o
   );

   modport slave (
      input  pps_i,
      input  clr_i,
      output pps_pulse_o,
      output period_o,
      output period_valid_o,
      output pps_count_o,
      output err_count_o,
      output locked_o,
      output missing_o
   );
endinterface

// File: rtl/wr_pps_monitor.sv
// Measures clk_sys cycles between PPS rising edges, qualifies each period
// against the nominal rate and keeps lock/missing status plus event counters.
module wr_pps_monitor #(
   parameter int unsigned CLK_FREQ       = 62500000,
   parameter int unsigned TOLERANCE      = 4,
   parameter int unsigned LOCK_COUNT     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 68750000
) (
   input  logic           clk_sys_i,
   input  logic           rst_n_i,
   wr_pps_monitor_if.slave bus
);

   // Window bounds are 33 bits wide so CLK_FREQ + TOLERANCE can never wrap.
   localparam logic [32:0] PERIOD_MIN  = (CLK_FREQ > TOLERANCE) ? 33'(CLK_FREQ - TOLERANCE) : 33'd0;
   localparam logic [32:0] PERIOD_MAX  = 33'(CLK_FREQ) + 33'(TOLERANCE);
   localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT_CYCLES);
   localparam logic [3:0]  LOCK_CNT    = 4'(LOCK_COUNT);
   localparam logic [4:0]  LOCK_CMP    = 5'(LOCK_COUNT);

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      RUN        = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic        pps_q_reg;
   logic [31:0] cnt_reg, cnt_next;
   logic [3:0]  good_run_reg, good_run_next;
   logic        pps_pulse_reg, pps_pulse_next;
   logic [31:0] period_reg, period_next;
   logic        period_valid_reg, period_valid_next;
   logic [31:0] pps_count_reg, pps_count_next;
   logic [15:0] err_count_reg, err_count_next;
   logic        locked_reg, locked_next;
   logic        missing_reg, missing_next;

   logic        rise;
   logic        period_good;
   logic        timeout;
   logic [4:0]  good_run_inc;
   logic        lock_hit;
   logic        count_err;

   assign rise         = bus.pps_i & ~pps_q_reg;
   assign period_good  = ({1'b0, cnt_reg} >= PERIOD_MIN) && ({1'b0, cnt_reg} <= PERIOD_MAX);
   assign timeout      = (cnt_reg == TIMEOUT_CNT);
   assign good_run_inc = {1'b0, good_run_reg} + 5'd1;
   assign lock_hit     = (good_run_inc >= LOCK_CMP);

   always_comb begin
      state_next        = state_reg;
      pps_pulse_next    = 1'b0;
      period_valid_next = 1'b0;
      period_next       = period_reg;
      pps_count_next    = pps_count_reg;
      err_count_next    = err_count_reg;
      good_run_next     = good_run_reg;
      locked_next       = locked_reg;
      missing_next      = missing_reg;
      count_err         = 1'b0;

      if (rise) begin
         cnt_next = 32'd1;
      end else if (cnt_reg == 32'hFFFF_FFFF) begin
         cnt_next = cnt_reg;
      end else begin
         cnt_next = cnt_reg + 32'd1;
      end

      case (state_reg)
         WAIT_FIRST: begin
            // First edge only establishes the phase; there is no period yet.
            if (rise) begin
               pps_pulse_next = 1'b1;
               pps_count_next = pps_count_reg + 32'd1;
               missing_next   = 1'b0;
               state_next     = RUN;
            end
         end
         RUN: begin
            if (rise) begin
               pps_pulse_next    = 1'b1;
               pps_count_next    = pps_count_reg + 32'd1;
               period_valid_next = 1'b1;
               period_next       = cnt_reg;
               if (period_good) begin
                  good_run_next = lock_hit ? LOCK_CNT : good_run_inc[3:0];
                  if (lock_hit) begin
                     locked_next = 1'b1;
                  end
               end else begin
                  good_run_next = 4'd0;
                  locked_next   = 1'b0;
                  count_err     = 1'b1;
               end
            end else if (timeout) begin
               // Leaving RUN guarantees the timeout is charged only once.
               missing_next  = 1'b1;
               locked_next   = 1'b0;
               good_run_next = 4'd0;
               count_err     = 1'b1;
               state_next    = WAIT_FIRST;
            end
         end
         default: state_next = WAIT_FIRST;
      endcase

      if (count_err && (err_count_reg != 16'hFFFF)) begin
         err_count_next = err_count_reg + 16'd1;
      end

      // Clear overrides any event landing in the same cycle.
      if (bus.clr_i) begin
         pps_count_next = 32'd0;
         err_count_next = 16'd0;
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg        <= WAIT_FIRST;
         pps_q_reg        <= 1'b1;
         cnt_reg          <= 32'd0;
         good_run_reg     <= 4'd0;
         pps_pulse_reg    <= 1'b0;
         period_reg       <= 32'd0;
         period_valid_reg <= 1'b0;
         pps_count_reg    <= 32'd0;
         err_count_reg    <= 16'd0;
         locked_reg       <= 1'b0;
         missing_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pps_q_reg        <= bus.pps_i;
         cnt_reg          <= cnt_next;
         good_run_reg     <= good_run_next;
         pps_pulse_reg    <= pps_pulse_next;
         period_reg       <= period_next;
         period_valid_reg <= period_valid_next;
         pps_count_reg    <= pps_count_next;
         err_count_reg    <= err_count_next;
         locked_reg       <= locked_next;
         missing_reg      <= missing_next;
      end
   end

   assign bus.pps_pulse_o    = pps_pulse_reg;
   assign bus.period_o       = period_reg;
   assign bus.period_valid_o = period_valid_reg;
   assign bus.pps_count_o    = pps_count_reg;
   assign bus.err_count_o    = err_count_reg;
   assign bus.locked_o       = locked_reg;
   assign bus.missing_o      = missing_reg;

endmodule

// File: tb/tb_wr_pps_monitor.sv
// Directed bench for wr_pps_monitor: expected responses are queued with each
// PPS edge and compared by an independent monitor on every strobe/timeout.
module tb_wr_pps_monitor;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;

   wr_pps_monitor_if bus();

   wr_pps_monitor #(
      .CLK_FREQ      (100),
      .TOLERANCE     (2),
      .LOCK_COUNT    (3),
      .TIMEOUT_CYCLES(150)
   ) dut (
      .clk_sys_i(clk_sys),
      .rst_n_i  (rst_n),
      .bus      (bus)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      bit          is_timeout;
      bit          pv;
      logic [31:0] period;
      logic [31:0] cnt;
      logic [15:0] err;
      bit          lk;
      bit          miss;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   since    = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   task automatic tick(int n);
      repeat (n) @(negedge clk_sys);
      since += n;
   endtask

   // Raise PPS exactly p negedges after the previous raise and hold it 5 cycles.
   task automatic rise(string name, int p, bit clr, bit pv, logic [31:0] per,
                       logic [31:0] cnt, logic [15:0] err, bit lk, bit miss);
      exp_t e;
      if (p > since) tick(p - since);
      e.is_timeout = 1'b0;
      e.pv = pv; e.period = per; e.cnt = cnt; e.err = err;
      e.lk = lk; e.miss = miss; e.name = name;
      exp_q.push_back(e);
      bus.pps_i = 1'b1;
      bus.clr_i = clr;
      since = 0;
      tick(1);
      bus.clr_i = 1'b0;
      tick(4);
      bus.pps_i = 1'b0;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_pulse"},  {31'd0, bus.pps_pulse_o}, 32'd0);
      chk({tag, "_period"}, bus.period_o, 32'd0);
      chk({tag, "_pvalid"}, {31'd0, bus.period_valid_o}, 32'd0);
      chk({tag, "_count"},  bus.pps_count_o, 32'd0);
      chk({tag, "_err"},    {16'd0, bus.err_count_o}, 32'd0);
      chk({tag, "_locked"}, {31'd0, bus.locked_o}, 32'd0);
      chk({tag, "_missing"},{31'd0, bus.missing_o}, 32'd0);
   endtask

   initial begin : monitor
      logic miss_prev;
      logic ev_pulse;
      logic ev_to;
      exp_t e;
      miss_prev = 1'b0;
      forever begin
         @(negedge clk_sys);
         ev_pulse  = bus.pps_pulse_o;
         ev_to     = bus.missing_o & ~miss_prev;
         miss_prev = bus.missing_o;
         if (ev_pulse || ev_to) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event actual pulse=%0b missing=%0b required no event",
                        ev_pulse, bus.missing_o);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_pulse"},   {31'd0, ev_pulse}, {31'd0, ~e.is_timeout});
               chk({e.name, "_pvalid"},  {31'd0, bus.period_valid_o}, {31'd0, e.pv});
               chk({e.name, "_period"},  bus.period_o, e.period);
               chk({e.name, "_count"},   bus.pps_count_o, e.cnt);
               chk({e.name, "_err"},     {16'd0, bus.err_count_o}, {16'd0, e.err});
               chk({e.name, "_locked"},  {31'd0, bus.locked_o}, {31'd0, e.lk});
               chk({e.name, "_missing"}, {31'd0, bus.missing_o}, {31'd0, e.miss});
               $display("txn %s pulse=%0b pv=%0b period=%0d count=%0d err=%0d locked=%0b missing=%0b",
                        e.name, ev_pulse, bus.period_valid_o, bus.period_o, bus.pps_count_o,
                        bus.err_count_o, bus.locked_o, bus.missing_o);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : stimulus
      exp_t t;
      bus.pps_i = 1'b0;
      bus.clr_i = 1'b0;
      rst_n     = 1'b0;
      tick(3);
      check_zero("reset");
      rst_n = 1'b1;
      tick(10);

      // Lock acquisition
      rise("r1_first", 20,  0, 0, 0,   1, 0, 0, 0);
      rise("r2",       100, 0, 1, 100, 2, 0, 0, 0);
      rise("r3",       100, 0, 1, 100, 3, 0, 0, 0);
      rise("r4_lock",  100, 0, 1, 100, 4, 0, 1, 0);
      // Tolerance edges
      rise("p98",      98,  0, 1, 98,  5, 0, 1, 0);
      rise("p102",     102, 0, 1, 102, 6, 0, 1, 0);
      rise("p97",      97,  0, 1, 97,  7, 1, 0, 0);
      rise("p103",     103, 0, 1, 103, 8, 2, 0, 0);
      rise("relock1",  100, 0, 1, 100, 9, 2, 0, 0);
      rise("relock2",  100, 0, 1, 100, 10, 2, 0, 0);
      rise("relock3",  100, 0, 1, 100, 11, 2, 1, 0);

      // Timeout: fires on the 150th cycle after the last rise, once
      t.is_timeout = 1'b1; t.pv = 1'b0; t.period = 100; t.cnt = 11;
      t.err = 3; t.lk = 1'b0; t.miss = 1'b1; t.name = "timeout";
      exp_q.push_back(t);
      tick(150 - since);
      chk("timeout_early_missing", {31'd0, bus.missing_o}, 32'd0);
      tick(1);
      chk("timeout_missing", {31'd0, bus.missing_o}, 32'd1);
      chk("timeout_locked",  {31'd0, bus.locked_o}, 32'd0);
      rise("after_to_first", 200, 0, 0, 100, 12, 3, 0, 0);
      rise("after_to_2",     100, 0, 1, 100, 13, 3, 0, 0);

      // Simultaneous events
      rise("rise_at_timeout", 150, 0, 1, 150, 14, 4, 0, 0);
      rise("clr_with_rise",   100, 1, 1, 100, 0,  0, 0, 0);
      rise("after_clr",       100, 0, 1, 100, 1,  0, 0, 0);

      // Reset mid-period with PPS high
      tick(45);
      rst_n     = 1'b0;
      bus.pps_i = 1'b1;
      tick(3);
      check_zero("in_reset");
      rst_n = 1'b1;
      tick(10);
      check_zero("post_reset_high");
      bus.pps_i = 1'b0;
      since = 0;
      rise("post_reset_first", 10,  0, 0, 0,   1, 0, 0, 0);
      rise("post_reset_2",     100, 0, 1, 100, 2, 0, 0, 0);

      // Saturation and wrap
      tick(2);
      force dut.err_count_reg = 16'hFFFF;
      force dut.pps_count_reg = 32'hFFFF_FFFF;
      tick(1);
      release dut.err_count_reg;
      release dut.pps_count_reg;
      rise("sat_wrap", 97, 0, 1, 97, 0, 16'hFFFF, 0, 0);

      tick(10);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wr_pps_monitor.md
# wr_pps_monitor

Receiving end of the White Rabbit PPS output. Sits in the `clk_sys` domain beside the WR core wrapper and takes the core's PPS as an input. It measures the number of `clk_sys` cycles between successive PPS rising edges and checks each period against the nominal frequency. It reports lock/missing status and event/error counters as software-readable registers.

## Interface
Parameters:
- `CLK_FREQ`, default 62500000: nominal `clk_sys` cycles per PPS period.
- `TOLERANCE`, default 4: allowed absolute deviation of a period from `CLK_FREQ`, in cycles.
- `LOCK_COUNT`, default 3: consecutive good periods required to assert lock (range 1–15).
- `TIMEOUT_CYCLES`, default 68750000: cycles without an edge before PPS is declared missing. Must be greater than `CLK_FREQ + TOLERANCE`.

Ports:
- `clk_sys_i` in 1: system clock. Single clock domain.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `pps_i` in 1: PPS from the WR core, synchronous to `clk_sys_i`, high for one or more cycles.
- `clr_i` in 1: synchronous clear of `pps_count_o` and `err_count_o`.
- `pps_pulse_o` out 1: single-cycle strobe, one per PPS rising edge.
- `period_o` out 32: last measured period, in cycles.
- `period_valid_o` out 1: single-cycle strobe when `period_o` is updated.
- `pps_count_o` out 32: number of PPS rising edges seen (wraps).
- `err_count_o` out 16: bad periods plus timeouts (saturates at 0xFFFF).
- `locked_o` out 1: PPS period stable.
- `missing_o` out 1: sticky flag; PPS timed out.

## Operation
- **Edge detect.** `pps_q <= pps_i` every cycle. A rise is `pps_i & ~pps_q`. `pps_q` resets to 1, so a PPS already high at reset release is not counted.
- **Cycle counter `cnt` (32 bit).**
  - On a rise, `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at `0xFFFFFFFF`.
  - The period between rises at edges k and k+P therefore reads P.
- **States.** `WAIT_FIRST` (reset state) and `RUN`.
  - `WAIT_FIRST`, on rise:
    - Pulse `pps_pulse_o`, increment `pps_count_o`, clear `missing_o`.
    - Go to `RUN`.
    - No period capture and no `period_valid_o`.
  - `RUN`, on rise:
    - Pulse `pps_pulse_o`, increment `pps_count_o`.
    - `period_o <= cnt`, pulse `period_valid_o`.
  - `RUN`, period classification:
    - Good if `CLK_FREQ - TOLERANCE <= cnt <= CLK_FREQ + TOLERANCE`; compare in 33-bit arithmetic, no wrap.
    - Good: `good_run <= min(good_run + 1, LOCK_COUNT)`. `locked_o <= 1` in the same cycle that `good_run + 1 >= LOCK_COUNT`.
    - Bad: `good_run <= 0`, `locked_o <= 0`, `err_count_o` +1.
  - `RUN`, no rise and `cnt == TIMEOUT_CYCLES`:
    - `missing_o <= 1`, `locked_o <= 0`, `good_run <= 0`, `err_count_o` +1.
    - Go to `WAIT_FIRST`. The timeout is counted exactly once.
- **Simultaneous events.**
  - A rise in the same cycle as `cnt == TIMEOUT_CYCLES`: the rise wins and no timeout occurs.
  - `clr_i` together with a rise or an error: `clr_i` wins. The counter goes to 0 and that event is not counted.
  - `clr_i` does not affect `period_o`, `locked_o`, `missing_o` or the state.
- **Width rules.**
  - `pps_count_o` wraps `0xFFFFFFFF -> 0`.
  - `err_count_o` holds at `0xFFFF`.

## Timing
- All outputs are registered. They update at the same clock edge that first samples `pps_i == 1`, so they are visible one cycle after `pps_i` rises.
- `pps_pulse_o` and `period_valid_o` are high for exactly one cycle per rise. A PPS held high for N cycles still produces one strobe.
- The first strobe after reset or after a timeout has `pps_pulse_o = 1` and `period_valid_o = 0`.
- **Reset.**
  - Outputs: `pps_pulse_o = 0`, `period_o = 0`, `period_valid_o = 0`, `pps_count_o = 0`, `err_count_o = 0`, `locked_o = 0`, `missing_o = 0`.
  - Internal: state `WAIT_FIRST`, `cnt = 0`, `good_run = 0`, `pps_q = 1`.
  - Reset asserted mid-period aborts the measurement. The next rise is treated as the first.

## Test plan
Bench parameters: `CLK_FREQ=100`, `TOLERANCE=2`, `LOCK_COUNT=3`, `TIMEOUT_CYCLES=150`.
- **Lock acquisition.** Rises every 100 cycles, each 5 cycles high.
  - After the 1st rise: `period_valid_o` stays 0.
  - Rises 2–4: `period_o = 100`.
  - `locked_o` rises with the 4th rise. `pps_count_o = 4`, `err_count_o = 0`.
- **Tolerance edges.** Periods 98, 102, 97, 103.
  - 98 and 102 are good.
  - 97 and 103 each add 1 to `err_count_o` and drop `locked_o`.
  - Three further good periods re-lock.
- **Timeout.** While locked, stop PPS.
  - 150 cycles after the last rise: `missing_o = 1`, `locked_o = 0`, `err_count_o` +1 exactly once.
  - Next rise clears `missing_o` with `period_valid_o = 0`.
  - Next rise at +100 gives `period_o = 100`.
- **Simultaneous events.**
  - Rise exactly at `cnt == 150`: no timeout, period 150 counted as a bad period.
  - `clr_i` on the same cycle as a rise: `pps_count_o = 0`.
- **Reset with PPS high.** Assert `rst_n_i` low mid-period while `pps_i = 1`, then release.
  - All outputs read 0.
  - No `pps_pulse_o` until `pps_i` falls and rises again.
- **Saturation and wrap.** Force `err_count_o = 0xFFFF` and `pps_count_o = 0xFFFFFFFF` via hierarchical deposit, then apply a bad period.
  - `err_count_o` holds at `0xFFFF`.
  - `pps_count_o` wraps to 0.
